// File: rtl/axi_lite_slave_strb.sv
// AXI4-Lite slave bridging bus transactions to a req/ack register port with byte strobes.
// Independent write and read engines, address-range DECERR and user-ack timeout SLVERR.
module axi_lite_slave_strb #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned STROBE_WIDTH   = DATA_WIDTH/8,
    parameter logic [63:0] ADDR_LIMIT     = 64'(1) << ADDR_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_awvalid,
    input  logic [ADDR_WIDTH-1:0]   i_awaddr,
    output logic                    o_awready,
    input  logic                    i_wvalid,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [STROBE_WIDTH-1:0] i_wstrb,
    output logic                    o_wready,
    output logic                    o_bvalid,
    input  logic                    i_bready,
    output logic [1:0]              o_bresp,
    input  logic                    i_arvalid,
    input  logic [ADDR_WIDTH-1:0]   i_araddr,
    output logic                    o_arready,
    output logic                    o_rvalid,
    input  logic                    i_rready,
    output logic [1:0]              o_rresp,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic                    o_wr_req,
    output logic [ADDR_WIDTH-1:0]   o_wr_addr,
    output logic [DATA_WIDTH-1:0]   o_wr_data,
    output logic [STROBE_WIDTH-1:0] o_wr_strb,
    input  logic                    i_wr_ack,
    input  logic                    i_wr_err,
    output logic                    o_rd_req,
    output logic [ADDR_WIDTH-1:0]   o_rd_addr,
    input  logic                    i_rd_ack,
    input  logic [DATA_WIDTH-1:0]   i_rd_data,
    input  logic                    i_rd_err
);

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;
    localparam bit          TO_EN       = (TIMEOUT_CYCLES != 0);
    // Counter value during the last cycle req may be high: req spans exactly TIMEOUT_CYCLES cycles.
    localparam logic [15:0] TO_LAST     = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {W_COLLECT, W_USER, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_USER, R_DATA} r_state_t;

    // ---------------- write engine ----------------
    w_state_t                w_state_q, w_state_d;
    logic                    aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic                    awready_d, wready_d, bvalid_d, wr_req_d;
    logic [1:0]              bresp_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_d;
    logic [STROBE_WIDTH-1:0] wr_strb_d;
    logic [15:0]             wcnt_q, wcnt_d;

    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awready_d = o_awready;
        wready_d  = o_wready;
        bvalid_d  = o_bvalid;
        bresp_d   = o_bresp;
        wr_req_d  = o_wr_req;
        wr_addr_d = o_wr_addr;
        wr_data_d = o_wr_data;
        wr_strb_d = o_wr_strb;
        wcnt_d    = wcnt_q;
        case (w_state_q)
            W_COLLECT: begin
                if (i_awvalid && o_awready) begin
                    aw_held_d = 1'b1;
                    wr_addr_d = i_awaddr;
                end
                if (i_wvalid && o_wready) begin
                    w_held_d  = 1'b1;
                    wr_data_d = i_wdata;
                    wr_strb_d = i_wstrb;
                end
                awready_d = !aw_held_d;
                wready_d  = !w_held_d;
                if (aw_held_d && w_held_d) begin
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    if (64'(wr_addr_d) >= ADDR_LIMIT) begin
                        bvalid_d  = 1'b1;
                        bresp_d   = RESP_DECERR;
                        w_state_d = W_RESP;
                    end else begin
                        wr_req_d  = 1'b1;
                        wcnt_d    = '0;
                        w_state_d = W_USER;
                    end
                end
            end
            W_USER: begin
                wcnt_d = wcnt_q + 16'd1;
                if (i_wr_ack) begin
                    wr_req_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    bresp_d   = i_wr_err ? RESP_SLVERR : RESP_OKAY;
                    w_state_d = W_RESP;
                end else if (TO_EN && wcnt_q == TO_LAST) begin
                    wr_req_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    bresp_d   = RESP_SLVERR;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (i_bready) begin
                    bvalid_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    w_state_d = W_COLLECT;
                end
            end
            default: w_state_d = W_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_COLLECT;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            o_awready <= 1'b0;
            o_wready  <= 1'b0;
            o_bvalid  <= 1'b0;
            o_bresp   <= '0;
            o_wr_req  <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
            o_wr_strb <= '0;
            wcnt_q    <= '0;
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            o_awready <= awready_d;
            o_wready  <= wready_d;
            o_bvalid  <= bvalid_d;
            o_bresp   <= bresp_d;
            o_wr_req  <= wr_req_d;
            o_wr_addr <= wr_addr_d;
            o_wr_data <= wr_data_d;
            o_wr_strb <= wr_strb_d;
            wcnt_q    <= wcnt_d;
        end
    end

    // ---------------- read engine ----------------
    r_state_t              r_state_q, r_state_d;
    logic                  arready_d, rvalid_d, rd_req_d;
    logic [1:0]            rresp_d;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [ADDR_WIDTH-1:0] rd_addr_d;
    logic [15:0]           rcnt_q, rcnt_d;

    always_comb begin
        r_state_d = r_state_q;
        arready_d = o_arready;
        rvalid_d  = o_rvalid;
        rresp_d   = o_rresp;
        rdata_d   = o_rdata;
        rd_req_d  = o_rd_req;
        rd_addr_d = o_rd_addr;
        rcnt_d    = rcnt_q;
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (i_arvalid && o_arready) begin
                    arready_d = 1'b0;
                    rd_addr_d = i_araddr;
                    if (64'(i_araddr) >= ADDR_LIMIT) begin
                        rvalid_d  = 1'b1;
                        rdata_d   = '0;
                        rresp_d   = RESP_DECERR;
                        r_state_d = R_DATA;
                    end else begin
                        rd_req_d  = 1'b1;
                        rcnt_d    = '0;
                        r_state_d = R_USER;
                    end
                end
            end
            R_USER: begin
                rcnt_d = rcnt_q + 16'd1;
                if (i_rd_ack) begin
                    rd_req_d  = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = i_rd_data;
                    rresp_d   = i_rd_err ? RESP_SLVERR : RESP_OKAY;
                    r_state_d = R_DATA;
                end else if (TO_EN && rcnt_q == TO_LAST) begin
                    rd_req_d  = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = '0;
                    rresp_d   = RESP_SLVERR;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (i_rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            o_arready <= 1'b0;
            o_rvalid  <= 1'b0;
            o_rresp   <= '0;
            o_rdata   <= '0;
            o_rd_req  <= 1'b0;
            o_rd_addr <= '0;
            rcnt_q    <= '0;
        end else begin
            r_state_q <= r_state_d;
            o_arready <= arready_d;
            o_rvalid  <= rvalid_d;
            o_rresp   <= rresp_d;
            o_rdata   <= rdata_d;
            o_rd_req  <= rd_req_d;
            o_rd_addr <= rd_addr_d;
            rcnt_q    <= rcnt_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_slave_strb.sv
// Directed bench for axi_lite_slave_strb: ADDR_LIMIT 0x100, TIMEOUT_CYCLES 8.
module tb_axi_lite_slave_strb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_awvalid = 1'b0, i_wvalid = 1'b0, i_bready = 1'b0;
    logic        i_arvalid = 1'b0, i_rready = 1'b0;
    logic [15:0] i_awaddr = '0, i_araddr = '0;
    logic [31:0] i_wdata = '0, i_rd_data = '0;
    logic [3:0]  i_wstrb = '0;
    logic        i_wr_ack = 1'b0, i_wr_err = 1'b0, i_rd_ack = 1'b0, i_rd_err = 1'b0;
    logic        o_awready, o_wready, o_bvalid, o_arready, o_rvalid, o_wr_req, o_rd_req;
    logic [1:0]  o_bresp, o_rresp;
    logic [31:0] o_rdata, o_wr_data;
    logic [15:0] o_wr_addr, o_rd_addr;
    logic [3:0]  o_wr_strb;

    int npass = 0, nfail = 0, ntotal = 0;

    axi_lite_slave_strb #(
        .ADDR_WIDTH(16), .DATA_WIDTH(32), .STROBE_WIDTH(4),
        .ADDR_LIMIT(64'h100), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .i_awvalid(i_awvalid), .i_awaddr(i_awaddr), .o_awready(o_awready),
        .i_wvalid(i_wvalid), .i_wdata(i_wdata), .i_wstrb(i_wstrb), .o_wready(o_wready),
        .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bresp(o_bresp),
        .i_arvalid(i_arvalid), .i_araddr(i_araddr), .o_arready(o_arready),
        .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rresp(o_rresp), .o_rdata(o_rdata),
        .o_wr_req(o_wr_req), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_wr_strb(o_wr_strb),
        .i_wr_ack(i_wr_ack), .i_wr_err(i_wr_err),
        .o_rd_req(o_rd_req), .o_rd_addr(o_rd_addr),
        .i_rd_ack(i_rd_ack), .i_rd_data(i_rd_data), .i_rd_err(i_rd_err)
    );

    always #5 clk = ~clk;

    logic [127:0] outs;
    assign outs = 128'({o_awready, o_wready, o_bvalid, o_bresp, o_arready, o_rvalid, o_rresp,
                        o_rdata, o_wr_req, o_wr_addr, o_wr_data, o_wr_strb, o_rd_req, o_rd_addr});

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // reset state
        tick(); tick();
        chk("reset_outs", outs, '0);
        rst = 1'b0;
        tick();
        chk("ready_after_reset", {o_awready, o_wready, o_arready}, 3'b111);

        // write 0x10, AW+W together, ack in cycle 3
        i_awvalid = 1; i_awaddr = 16'h0010; i_wvalid = 1; i_wdata = 32'hDEADBEEF; i_wstrb = 4'b0101;
        tick();
        i_awvalid = 0; i_wvalid = 0;
        chk("wr_c1", {o_wr_req, o_wr_addr, o_wr_data, o_wr_strb, o_awready, o_wready},
            {1'b1, 16'h0010, 32'hDEADBEEF, 4'b0101, 2'b00});
        tick();
        chk("wr_c2_req", o_wr_req, 1);
        tick();
        chk("wr_c3_req", {o_wr_req, o_bvalid}, 2'b10);
        i_wr_ack = 1;
        tick();
        i_wr_ack = 0;
        chk("wr_c4_resp", {o_wr_req, o_bvalid, o_bresp}, {1'b0, 1'b1, 2'b00});
        i_bready = 1;
        tick();
        i_bready = 0;
        chk("wr_b_done", {o_bvalid, o_awready, o_wready}, 3'b011);

        // W five cycles ahead of AW
        i_wvalid = 1; i_wdata = 32'hCAFEF00D; i_wstrb = 4'b1010;
        tick();
        i_wvalid = 0; i_wdata = '0; i_wstrb = '0;
        chk("w_first_ready", {o_wready, o_awready, o_wr_req}, 3'b010);
        for (int i = 0; i < 4; i++) tick();
        chk("w_first_no_req", o_wr_req, 0);
        i_awvalid = 1; i_awaddr = 16'h0020;
        tick();
        i_awvalid = 0;
        chk("w_first_req", {o_wr_req, o_wr_addr, o_wr_data, o_wr_strb},
            {1'b1, 16'h0020, 32'hCAFEF00D, 4'b1010});
        i_wr_ack = 1;
        tick();
        i_wr_ack = 0;
        chk("w_first_resp", {o_bvalid, o_bresp}, 3'b100);
        i_bready = 1; tick(); i_bready = 0;

        // out-of-range write
        i_awvalid = 1; i_awaddr = 16'h0200; i_wvalid = 1; i_wdata = 32'h1; i_wstrb = 4'hF;
        tick();
        i_awvalid = 0; i_wvalid = 0;
        chk("wr_decerr", {o_wr_req, o_bvalid, o_bresp}, {1'b0, 1'b1, 2'b11});
        i_bready = 1; tick(); i_bready = 0;

        // out-of-range read
        i_arvalid = 1; i_araddr = 16'h0104;
        tick();
        i_arvalid = 0;
        chk("rd_decerr", {o_rd_req, o_rvalid, o_rresp, o_rdata}, {1'b0, 1'b1, 2'b11, 32'h0});
        i_rready = 1; tick(); i_rready = 0;
        chk("rd_decerr_done", {o_rvalid, o_arready}, 2'b01);

        // read timeout
        i_arvalid = 1; i_araddr = 16'h0008;
        tick();
        i_arvalid = 0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!o_rd_req) break;
            n++;
            tick();
        end
        chk("rd_to_len", n, 8);
        chk("rd_to_resp", {o_rvalid, o_rresp, o_rdata}, {1'b1, 2'b10, 32'h0});
        i_rready = 1; tick(); i_rready = 0;

        // ack in the final timeout cycle wins
        i_arvalid = 1; i_araddr = 16'h0008;
        tick();
        i_arvalid = 0;
        for (int i = 0; i < 7; i++) tick();
        chk("rd_c8_req", {o_rd_req, o_rvalid}, 2'b10);
        i_rd_ack = 1; i_rd_data = 32'h12345678;
        tick();
        i_rd_ack = 0; i_rd_data = '0;
        chk("rd_ack_c8", {o_rd_req, o_rvalid, o_rresp, o_rdata}, {1'b0, 1'b1, 2'b00, 32'h12345678});
        i_rready = 1; tick(); i_rready = 0;

        // concurrent write and read, read acked first, write acked with error
        i_awvalid = 1; i_awaddr = 16'h0004; i_wvalid = 1; i_wdata = 32'h0F0F0F0F; i_wstrb = 4'hF;
        i_arvalid = 1; i_araddr = 16'h0008;
        tick();
        i_awvalid = 0; i_wvalid = 0; i_arvalid = 0;
        chk("conc_reqs", {o_wr_req, o_rd_req, o_rd_addr}, {2'b11, 16'h0008});
        i_rd_ack = 1; i_rd_data = 32'hA5A5A5A5;
        tick();
        i_rd_ack = 0;
        chk("conc_rd_first", {o_rvalid, o_rresp, o_rdata, o_bvalid, o_wr_req},
            {1'b1, 2'b00, 32'hA5A5A5A5, 2'b01});
        i_rready = 1; i_wr_ack = 1; i_wr_err = 1;
        tick();
        i_rready = 0; i_wr_ack = 0; i_wr_err = 0;
        chk("conc_wr_err", {o_bvalid, o_bresp, o_rvalid}, {1'b1, 2'b10, 1'b0});
        i_bready = 1; tick(); i_bready = 0;

        // backpressure on both response channels
        i_awvalid = 1; i_awaddr = 16'h0030; i_wvalid = 1; i_wdata = 32'h0BADF00D; i_wstrb = 4'b0011;
        tick();
        i_awvalid = 0; i_wvalid = 0;
        i_wr_ack = 1; i_arvalid = 1; i_araddr = 16'h0040;
        tick();
        i_wr_ack = 0; i_arvalid = 0;
        i_rd_ack = 1; i_rd_data = 32'h5A5A0001;
        tick();
        i_rd_ack = 0; i_rd_data = '0;
        for (int i = 0; i < 10; i++) begin
            chk("stall_hold", {o_bvalid, o_bresp, o_rvalid, o_rresp, o_rdata, o_awready, o_arready},
                {1'b1, 2'b00, 1'b1, 2'b00, 32'h5A5A0001, 2'b00});
            tick();
        end
        i_bready = 1; tick(); i_bready = 0;

        // reset mid-W_USER (read still stalled)
        i_awvalid = 1; i_awaddr = 16'h0050; i_wvalid = 1; i_wdata = 32'h77777777; i_wstrb = 4'hF;
        tick();
        i_awvalid = 0; i_wvalid = 0;
        chk("mid_user_req", {o_wr_req, o_rvalid}, 2'b11);
        tick();
        rst = 1;
        tick();
        chk("mid_reset_outs", outs, '0);
        rst = 0;
        tick();
        chk("post_reset_ready", {o_awready, o_wready, o_arready, o_bvalid, o_rvalid}, 5'b11100);

        // fresh write after reset
        i_awvalid = 1; i_awaddr = 16'h0060; i_wvalid = 1; i_wdata = 32'h11223344; i_wstrb = 4'hF;
        tick();
        i_awvalid = 0; i_wvalid = 0;
        chk("post_wr_req", {o_wr_req, o_wr_addr, o_wr_data, o_wr_strb},
            {1'b1, 16'h0060, 32'h11223344, 4'hF});
        i_wr_ack = 1;
        tick();
        i_wr_ack = 0;
        chk("post_wr_resp", {o_bvalid, o_bresp, o_wr_req}, 4'b1000);
        i_bready = 1; tick(); i_bready = 0;
        chk("post_wr_done", {o_bvalid, o_awready}, 2'b01);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
